// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect inputs, instruction-memory port, IF/ID register and status.
// The slave modport is the fetch unit; the master modport is whatever surrounds it.
interface fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        fetch_halted;
  logic [31:0] fetch_count;
  logic        misalign_err;

  modport slave (
    input  stall, redirect_valid, redirect_target, imem_rdata,
    output imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr,
           fetch_halted, fetch_count, misalign_err
  );

  modport master (
    output stall, redirect_valid, redirect_target, imem_rdata,
    input  imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr,
           fetch_halted, fetch_count, misalign_err
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch: PC owner, IF/ID register one clock after imem_addr; stall holds, redirect wins over stall.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect halts and pulses misalign_err instead of truncating the target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  fetch_unit_if.slave   bus
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  // Widened so IMEM_WORDS*4 = 2^32 still compares correctly.
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc4;
  logic [31:0] r_if_instr;
  logic [31:0] r_count;
  logic        r_misalign;

  wire [31:0] w_pc_plus4 = r_pc + 32'd4;
  wire [31:0] w_target   = {bus.redirect_target[31:2], 2'b00};
  wire        w_oob      = {1'b0, r_pc} >= IMEM_BYTES;
  wire        w_misalign;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_misalign = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
  wire w_unused_tgt_lsbs = ^bus.redirect_target[1:0];
`endif

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'd0;
      r_if_pc4   <= 32'd0;
      r_if_instr <= 32'd0;
      r_count    <= 32'd0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        S_BOOT: r_state <= S_RUN;
        S_RUN, S_HALT: begin
          if (bus.redirect_valid) begin
            r_if_valid <= 1'b0;
            if (w_misalign) begin
              r_state    <= S_HALT;
              r_misalign <= 1'b1;
            end else begin
              r_pc    <= w_target;
              r_state <= S_RUN;
            end
          end else if (r_state == S_HALT) begin
            r_if_valid <= 1'b0;
          end else if (w_oob) begin
            r_state    <= S_HALT;
            r_if_valid <= 1'b0;
          end else if (!bus.stall) begin
            r_if_instr <= bus.imem_rdata;
            r_if_pc    <= r_pc;
            r_if_pc4   <= w_pc_plus4;
            r_if_valid <= 1'b1;
            r_pc       <= w_pc_plus4;
            r_count    <= r_count + 32'd1;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign bus.imem_addr      = r_pc;
  assign bus.if_id_valid    = r_if_valid;
  assign bus.if_id_pc       = r_if_pc;
  assign bus.if_id_pc_plus4 = r_if_pc4;
  assign bus.if_id_instr    = r_if_instr;
  assign bus.fetch_halted   = (r_state == S_HALT);
  assign bus.fetch_count    = r_count;
  assign bus.misalign_err   = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a per-cycle reference model of the fetch rules.
module tb_fetch_unit;
  localparam int IMEM_WORDS = 32;
  localparam longint LIMIT  = longint'(IMEM_WORDS) * 4;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(IMEM_WORDS)) dut (
    .i_clk(clk), .i_resetn(resetn), .bus(bus)
  );

  // Memory image: word at byte address a is "addi x0,x0,a" style (a<<20 | 0x13).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 20) | 32'h13;
  endfunction
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  int n_chk = 0;
  int n_err = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  bit          m_booting, m_halted, m_vld, m_mis;
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;

  task automatic model_reset();
    m_booting = 1; m_halted = 0; m_vld = 0; m_mis = 0;
    m_pc = 0; m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_cnt = 0;
  endtask

  always @(negedge resetn) model_reset();

  always @(posedge clk) begin
    if (resetn) begin
      m_mis = 0;
      if (m_booting) begin
        m_booting = 0;
      end else if (bus.redirect_valid) begin
        m_vld = 0;
        if (TRAP && bus.redirect_target[1:0] != 2'b00) begin
          m_halted = 1; m_mis = 1;
        end else begin
          m_pc = bus.redirect_target & ~32'd3;
          m_halted = 0;
        end
      end else if (m_halted) begin
        m_vld = 0;
      end else if (longint'(m_pc) >= LIMIT) begin
        m_halted = 1; m_vld = 0;
      end else if (!bus.stall) begin
        m_instr = mem_word(m_pc);
        m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
        m_vld = 1; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("if_id_valid", 32'(bus.if_id_valid), 32'(m_vld));
      chk("if_id_pc", bus.if_id_pc, m_ipc);
      chk("if_id_pc_plus4", bus.if_id_pc_plus4, m_ipc4);
      chk("if_id_instr", bus.if_id_instr, m_instr);
      chk("fetch_halted", 32'(bus.fetch_halted), 32'(m_halted));
      chk("fetch_count", bus.fetch_count, m_cnt);
      chk("misalign_err", 32'(bus.misalign_err), 32'(m_mis));
    end
  end

  task automatic nx(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic redir(input logic [31:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = t;
  endtask

  initial begin
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_target = 0;
    #1 resetn = 1'b0;
    model_reset();
    started = 1'b1;
    nx(2);
    chk("rst_valid", 32'(bus.if_id_valid), 32'd0);
    chk("rst_count", bus.fetch_count, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    chk("rst_halted", 32'(bus.fetch_halted), 32'd0);

    // Boot then sequential fetch
    resetn = 1'b1;
    nx();
    chk("boot_valid", 32'(bus.if_id_valid), 32'd0);
    chk("boot_addr", bus.imem_addr, 32'd0);
    nx();
    chk("first_pc", bus.if_id_pc, 32'h0);
    chk("first_valid", 32'(bus.if_id_valid), 32'd1);
    nx(2);
    chk("third_pc", bus.if_id_pc, 32'h8);
    chk("third_instr", bus.if_id_instr, 32'h0080_0013);
    chk("third_count", bus.fetch_count, 32'd3);
    nx();

    // Stall for 3 cycles with pc=0x10
    chk("pre_stall_addr", bus.imem_addr, 32'h10);
    bus.stall = 1;
    nx(3);
    chk("stall_pc", bus.if_id_pc, 32'h0C);
    chk("stall_addr", bus.imem_addr, 32'h10);
    chk("stall_count", bus.fetch_count, 32'd4);
    bus.stall = 0;
    nx();
    chk("resume_pc", bus.if_id_pc, 32'h10);

    // Redirect beats a simultaneous stall
    bus.stall = 1; redir(32'h40);
    nx();
    chk("redir_bubble", 32'(bus.if_id_valid), 32'd0);
    chk("redir_addr", bus.imem_addr, 32'h40);
    bus.stall = 0; bus.redirect_valid = 0;
    nx();
    chk("redir_pc", bus.if_id_pc, 32'h40);

    // Misaligned redirect
    redir(32'h22);
    nx();
    bus.redirect_valid = 0;
    chk("mis_pulse", 32'(bus.misalign_err), TRAP ? 32'd1 : 32'd0);
    chk("mis_addr", bus.imem_addr, TRAP ? 32'h44 : 32'h20);
    chk("mis_halt", 32'(bus.fetch_halted), TRAP ? 32'd1 : 32'd0);
    nx();
    chk("mis_pulse_end", 32'(bus.misalign_err), 32'd0);

    // Run off the end of memory
    redir(32'h70);
    nx();
    bus.redirect_valid = 0;
    nx(5);
    chk("oob_halt", 32'(bus.fetch_halted), 32'd1);
    chk("oob_valid", 32'(bus.if_id_valid), 32'd0);
    chk("oob_addr", bus.imem_addr, 32'h80);
    bus.stall = 1;
    nx(2);
    chk("halt_hold", 32'(bus.fetch_halted), 32'd1);
    redir(32'h0);
    nx();
    bus.redirect_valid = 0; bus.stall = 0;
    chk("unhalt", 32'(bus.fetch_halted), 32'd0);
    nx();
    chk("unhalt_pc", bus.if_id_pc, 32'h0);
    chk("unhalt_valid", 32'(bus.if_id_valid), 32'd1);

    // Redirect straight to an out-of-range target
    redir(32'h1000);
    nx();
    bus.redirect_valid = 0;
    chk("far_not_halted", 32'(bus.fetch_halted), 32'd0);
    nx();
    chk("far_halted", 32'(bus.fetch_halted), 32'd1);
    redir(32'h10);
    nx();
    bus.redirect_valid = 0;
    nx(2);
    chk("pre_reset_addr", bus.imem_addr, 32'h18);

    // Asynchronous reset mid-run, redirect held across boot
    #2 resetn = 1'b0;
    #1;
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_valid", 32'(bus.if_id_valid), 32'd0);
    chk("arst_count", bus.fetch_count, 32'd0);
    chk("arst_pc", bus.if_id_pc, 32'h0);
    nx();
    resetn = 1'b1; redir(32'h40);
    nx();
    bus.redirect_valid = 0;
    chk("boot_ignores_redir", bus.imem_addr, 32'h0);
    nx();
    chk("reboot_pc", bus.if_id_pc, 32'h0);
    chk("reboot_valid", 32'(bus.if_id_valid), 32'd1);
    nx(3);

    started = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
    $fatal(1);
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV32I core, directly upstream of the word-addressed instruction memory.
- Owns the program counter and drives the memory read address.
- Captures the combinational read data into the IF/ID pipeline register.
- Handles stalls, branch/jump redirects, a post-reset boot cycle and halt-on-out-of-bounds fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_WORDS, 256, instruction memory depth in 32-bit words; valid fetch range is 0 to IMEM_WORDS*4-1.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  reset, asynchronous, active-low.
- stall  input  1  hold PC and IF/ID contents (hazard unit).
- redirect_valid  input  1  take redirect_target this cycle (branch/jump from EX).
- redirect_target  input  32  byte address of next instruction.
- imem_addr  output  32  byte address to instruction memory; equals pc combinationally.
- imem_rdata  input  32  instruction word; combinational from imem_addr, same cycle.
- if_id_valid  output  1  IF/ID register holds a real instruction.
- if_id_pc  output  32  PC of captured instruction.
- if_id_pc_plus4  output  32  if_id_pc + 4.
- if_id_instr  output  32  captured instruction.
- fetch_halted  output  1  FSM in HALT.
- fetch_count  output  32  number of instructions delivered (valid captures).
- misalign_err  output  1  one-cycle pulse on misaligned redirect (optional feature; tied 0 otherwise).

Behaviour:
- Reset (async, resetn=0):
  - pc=RESET_PC; state=BOOT.
  - if_id_valid=0; if_id_pc, if_id_pc_plus4, if_id_instr = 0.
  - fetch_halted=0; fetch_count=0; misalign_err=0.
- FSM states BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one clock after reset deassertion; memory contents settle.
  - pc holds; if_id_valid stays 0; next state RUN.
  - redirect_valid is ignored in BOOT.
- RUN, priority per rising edge:
  1. redirect_valid=1:
     - pc <= redirect_target with [1:0] forced to 0.
     - if_id_valid <= 0 (bubble); stall is ignored.
     - If the target is out of range, the next cycle's OOB check applies.
  2. Else if pc >= IMEM_WORDS*4:
     - Next state HALT; if_id_valid <= 0; pc holds.
  3. Else if stall=1:
     - pc and all if_id_* hold; fetch_count holds.
  4. Else:
     - if_id_instr <= imem_rdata; if_id_pc <= pc; if_id_pc_plus4 <= pc+4.
     - if_id_valid <= 1; pc <= pc+4; fetch_count <= fetch_count+1.
- HALT:
  - pc holds; if_id_valid=0; fetch_halted=1.
  - redirect_valid=1 loads pc per rule 1 and returns to RUN.
  - stall is ignored.
- Arithmetic: pc+4 wraps modulo 2^32; fetch_count wraps modulo 2^32.
- Latency: an instruction at pc appears on if_id_* one clock after imem_addr=pc, absent stall.
- Redirect: target instruction is valid two edges after redirect_valid is sampled.
- Reset mid-operation: all state returns to reset values immediately; the next deassertion re-enters BOOT.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Redirect with target[1:0]!=0 in RUN or HALT does not update pc.
  - State -> HALT; if_id_valid <= 0.
  - misalign_err pulses high for exactly one cycle, registered on the edge that sampled the redirect.
- Undefined:
  - target[1:0] silently forced to 0 per rule 1.
  - misalign_err constant 0.

Test Plan:
- Reset release, no stall/redirect, RESET_PC=0 -> BOOT one cycle, then if_id_pc = 0, 4, 8 on consecutive edges; if_id_instr matches memory words 0, 1, 2; fetch_count=3.
- stall=1 for 3 cycles with pc=0x10 -> pc, if_id_pc=0x0C, if_id_instr frozen; fetch_count unchanged; resumes with 0x10 after stall drops.
- redirect_valid=1, target=0x40, simultaneous with stall=1 -> next edge if_id_valid=0, pc=0x40; following edge if_id_pc=0x40, if_id_valid=1.
- IMEM_WORDS=4, run from 0 -> after delivering pc 0xC, pc=0x10 triggers HALT; fetch_halted=1, if_id_valid=0; redirect to 0x0 -> RUN, if_id_pc=0 two edges later.
- redirect target 0x22:
  - With FETCH_MISALIGN_TRAP_EN: misalign_err one-cycle pulse, HALT, pc unchanged.
  - Without: pc=0x20, no halt.
- Assert resetn=0 mid-run at pc=0x18 -> outputs immediately at reset values; after release, BOOT then fetch from RESET_PC.
